// File: rtl/sa_pkg.sv
// sa_pkg: shared constants, bank encoding, loader state type and address
// helpers for the systolic-array skew loader.
//   LANES/DATA_W/COL_W/K_W : array geometry and field widths
//   MAX_K                  : largest honoured inner-dimension length
//   ADDR_W                 : memory address width, {lane, column}
package sa_pkg;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int COL_W  = 8;
  localparam int K_W    = 5;
  localparam int MAX_K  = 16;
  localparam int LANE_W = $clog2(LANES);
  localparam int ADDR_W = COL_W + LANE_W;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_POST,
    ST_FIN
  } state_t;

  function automatic logic [ADDR_W-1:0] mem_addr_of(input logic [LANE_W-1:0] lane,
                                                    input logic [COL_W-1:0]  col);
    return {lane, col};
  endfunction

  function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k);
    return (k > K_W'(MAX_K)) ? K_W'(MAX_K) : k;
  endfunction

endpackage

// File: rtl/sa_skew_addr_gen.sv
// sa_skew_addr_gen: lane/position counters for the skewed load.
// Within one lane the column offset simply runs 0 .. K+LANES-2; the PRE,
// DATA and POST phases are just ranges of that offset, so one counter
// covers all three and the phase of the next slot falls out of compares.
//   start      : load base/K, restart at lane 0 offset 0
//   step       : current slot has been written, advance
//   addr       : {lane, (base + offset) mod 2^COL_W}
//   next_pre   : next offset (same lane) is a leading pad slot
//   next_data  : next offset (same lane) is a data slot
//   lane_end   : current slot is the last of its lane
//   last_lane  : current lane is LANES-1
//   final_elem : current data slot is the final element of the load
module sa_skew_addr_gen
  import sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [K_W-1:0]    k_in,
  input  logic [COL_W-1:0]  base_in,
  output logic [ADDR_W-1:0] addr,
  output logic              next_pre,
  output logic              next_data,
  output logic              lane_end,
  output logic              last_lane,
  output logic              final_elem
);

  logic [LANE_W-1:0] lane;
  logic [COL_W-1:0]  pos;
  logic [COL_W-1:0]  base;
  logic [K_W-1:0]    k_len;
  logic [COL_W-1:0]  pos_nxt;
  logic [COL_W-1:0]  lane_ext;
  logic [COL_W-1:0]  k_ext;
  logic [COL_W-1:0]  col;

  always_comb begin
    pos_nxt  = pos + COL_W'(1);
    lane_ext = COL_W'(lane);
    k_ext    = COL_W'(k_len);
    col      = base + pos;  // wraps silently past the last column
  end

  assign next_pre   = pos_nxt < lane_ext;
  assign next_data  = pos_nxt < (lane_ext + k_ext);
  assign lane_end   = pos == (k_ext + COL_W'(LANES - 2));
  assign last_lane  = lane == LANE_W'(LANES - 1);
  assign final_elem = last_lane && !next_data;
  assign addr       = mem_addr_of(lane, col);

  always_ff @(posedge clk) begin
    if (rst) begin
      lane  <= '0;
      pos   <= '0;
      base  <= '0;
      k_len <= '0;
    end else if (start) begin
      lane  <= '0;
      pos   <= '0;
      base  <= base_in;
      k_len <= k_in;
    end else if (step) begin
      if (lane_end) begin
        lane <= lane + LANE_W'(1);
        pos  <= '0;
      end else begin
        pos <= pos_nxt;
      end
    end
  end

endmodule

// File: rtl/sa_skew_loader.sv
// sa_skew_loader: writes a lane-major element stream into systolic-array
// input bank A or B with the diagonal skew applied (lane r shifted right
// by r columns) and every pad slot explicitly written with zero.
//   cmd_*   : load command (bank select, K, base column); cmd_ready in IDLE
//   s_*     : element stream, accepted only while in DATA
//   mem_*   : registered write port, one strobe per bank
//   done    : one-cycle pulse the cycle after the final write
//   err     : sticky s_last framing error, cleared by the next command
//
// state | meaning
// IDLE  | waiting for a command
// PRE   | leading zero pads of lane r (r slots)
// DATA  | stream elements of lane r (K slots)
// POST  | trailing zero pads of lane r (LANES-1-r slots)
// FIN   | final write has retired; raise done, then back to IDLE
module sa_skew_loader
  import sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_sel,
  input  logic [K_W-1:0]    cmd_k,
  input  logic [COL_W-1:0]  cmd_base,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we_a,
  output logic              mem_we_b,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            after_step;
  logic              sel;
  logic [K_W-1:0]    k_clamped;
  logic              start;
  logic              accept;
  logic              pad;
  logic              step;
  logic [ADDR_W-1:0] gen_addr;
  logic              next_pre;
  logic              next_data;
  logic              lane_end;
  logic              last_lane;
  logic              final_elem;

  assign k_clamped = clamp_k(cmd_k);
  assign cmd_ready = (state == ST_IDLE);
  assign s_ready   = (state == ST_DATA);
  assign start     = cmd_valid && cmd_ready;
  assign accept    = s_valid && s_ready;
  assign pad       = (state == ST_PRE) || (state == ST_POST);
  assign step      = pad || accept;

  sa_skew_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step       (step),
    .k_in       (k_clamped),
    .base_in    (cmd_base),
    .addr       (gen_addr),
    .next_pre   (next_pre),
    .next_data  (next_data),
    .lane_end   (lane_end),
    .last_lane  (last_lane),
    .final_elem (final_elem)
  );

  // Empty phases are skipped by picking the phase of the next slot directly;
  // a new lane always starts in PRE because its lane index is non-zero.
  always_comb begin
    after_step = ST_POST;
    if (lane_end)       after_step = last_lane ? ST_FIN : ST_PRE;
    else if (next_pre)  after_step = ST_PRE;
    else if (next_data) after_step = ST_DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel      <= BANK_A;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we_a <= 1'b0;
      mem_we_b <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_we_a <= 1'b0;
      mem_we_b <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel   <= cmd_sel;
            err   <= 1'b0;
            // lane 0 has no leading pads
            state <= (k_clamped != '0) ? ST_DATA : ST_POST;
          end
        end
        ST_PRE, ST_POST: begin
          mem_we_a <= (sel == BANK_A);
          mem_we_b <= (sel == BANK_B);
          mem_addr <= gen_addr;
          mem_data <= '0;
          state    <= after_step;
        end
        ST_DATA: begin
          if (s_valid) begin
            mem_we_a <= (sel == BANK_A);
            mem_we_b <= (sel == BANK_B);
            mem_addr <= gen_addr;
            mem_data <= s_data;
            if (s_last != final_elem) err <= 1'b1;
            state    <= after_step;
          end
        end
        ST_FIN: begin
          // first FIN cycle is the one where the last write is visible;
          // done follows it, and IDLE only after done has been seen
          if (!done) done <= 1'b1;
          else       state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sa_skew_loader.md
Name: sa_skew_loader

Overview:
- Host-side writer for the systolic-array input memories (A and B banks, each 4 lanes x 256 columns x 16 bit, address = lane*256 + column).
- Takes an unskewed, lane-major element stream and writes it into the selected bank with the diagonal skew the array requires: lane r is delayed by r columns, and every pad slot is explicitly zero-filled.
- Sits between the host/testbench stream source and the enA/addrA/dataA and enB/addrB/dataB write ports of the accelerator top.

Parameters:
- LANES, 4, number of array rows/columns (memory lanes).
- DATA_W, 16, element width.
- COL_W, 8, column address width (256 columns per lane).
- K_W, 5, width of the inner-dimension length field (K range 0..16).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  load command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_sel  in  1  0 = bank A, 1 = bank B.
- cmd_k  in  K_W  elements per lane, K (0..16; values above 16 are treated as 16).
- cmd_base  in  COL_W  starting column.
- s_valid  in  1  element valid.
- s_ready  out  1  element accepted when s_valid && s_ready.
- s_data  in  DATA_W  element; order is lane 0 k=0..K-1, then lane 1, ..., then lane 3.
- s_last  in  1  must mark the final element of lane LANES-1.
- mem_addr  out  COL_W+2  {lane, column}.
- mem_data  out  DATA_W  write data.
- mem_we_a  out  1  write strobe for bank A.
- mem_we_b  out  1  write strobe for bank B.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  sticky framing error; cleared by the next accepted command or by rst.

Behaviour:
- **Reset:**
  - State = IDLE.
  - cmd_ready = 1, s_ready = 0.
  - mem_we_a = mem_we_b = 0, mem_addr = 0, mem_data = 0.
  - done = 0, err = 0.
- **Reset mid-load:** abandon the load immediately. No further writes and no done pulse. Already-written entries are left as they are.
- **Command latch:** on cmd_valid && cmd_ready, latch sel, K, base; set lane = 0, col = 0; clear err.
- **States:** IDLE, PRE, DATA, POST, FIN.
  - IDLE: wait for a command; go to PRE.
  - PRE (lane r): write zeros at columns 0..r-1 relative to base, one per cycle. Skipped when r = 0.
  - DATA: s_ready = 1 (combinational from state). Each accepted element writes column r+k. A cycle with s_valid low produces no write. Advance after K accepts; skipped when K = 0.
  - POST: write zeros at columns r+K .. K+LANES-2, i.e. LANES-1-r writes. Then move to lane r+1 in PRE, or, after the last lane, go to FIN.
  - FIN: assert done for one cycle; return to IDLE.
- **Write count:** a load performs exactly LANES*(K+LANES-1) writes (4*(K+3)).
- **Output timing:**
  - All mem_* outputs are registered: the write decided in cycle t appears on the outputs in cycle t+1.
  - The first write appears 2 cycles after the command handshake (PRE entered at t+1, write visible at t+2).
  - Pad writes are issued back-to-back with no stalls.
- **Done timing:** done is asserted in the cycle immediately after the final mem_we cycle. cmd_ready returns high in the cycle after done.
- **Strobe rules:**
  - Exactly one of mem_we_a / mem_we_b is asserted per write, chosen by the latched sel.
  - mem_data = 0 on pad writes.
- **Addressing:**
  - Column = (base + offset) mod 2^COL_W; the wrap from 255 to 0 is silent.
  - mem_addr = lane*2^COL_W + column.
- **Framing:**
  - err is set if s_last is seen on any accepted element other than the final one.
  - err is set if s_last is absent on the final accepted element.
  - The load always completes using K as the length, regardless of err.
- **Simultaneous events:** a new cmd_valid during a load is ignored (cmd_ready = 0). s_valid outside DATA is not accepted.

Decomposition:
- Shared package (sa_pkg):
  - LANES, DATA_W, COL_W, K_W, MAX_K = 16.
  - Bank-select encoding: BANK_A = 0, BANK_B = 1.
  - State enum.
  - Memory address helper: lane concatenated with column.
- One sub-module is natural: sa_skew_addr_gen, which holds the lane/column counters, the pad-count comparisons and the base+offset wrap. The FSM and the stream handshake stay in the top.

Test Plan:
- **Basic load, bank A:** K=2, base=0, sel=A, s_data 1..8 continuous, s_last on 8.
  - 20 writes, all with mem_we_a.
  - Lane 0: cols 0..4 = 1,2,0,0,0. Lane 1: 0,3,4,0,0. Lane 2: 0,0,5,6,0. Lane 3: 0,0,0,7,8.
  - done pulses once; err = 0; mem_we_b never asserted.
- **Column wrap, bank B:** K=4, base=254, sel=B, 16 elements.
  - Lane 3 data lands at cols 1,2,3,4 (addrs 769..772).
  - 28 writes total, all with mem_we_b.
- **Stream backpressure:** K=3, s_valid toggled every other cycle.
  - Write contents are identical to a continuous stream; no write is issued in idle data cycles.
  - done arrives 1 cycle after the last write.
- **Zero-length load:** K=0.
  - 12 zero writes; s_ready never asserted; done pulses.
- **Framing errors:**
  - s_last asserted on element 3 of a K=2 load → err = 1 and stays high; the load still makes 20 writes.
  - The next accepted command clears err.
- **Reset mid-load:** assert rst during lane 1 of a K=4 load.
  - The next cycle has no mem_we and cmd_ready = 1; done is never pulsed.
  - A follow-up K=1 load completes normally with 16 writes.
